ecc_scrubber: RTL
=================

Name: ecc_scrubber

Overview:
- Background scrub controller for one single-port SRAM bank that stores SECDED-encoded words.
- Sits between the interconnect port and the bank. It shares the bank between core traffic and an internal scrub engine, and core traffic always has priority.
- The scrub engine walks the bank, reads each word, decodes it, and writes back corrected words.
- It reports corrected and uncorrectable events.

Parameters:
- BankSize, 256, number of words in the bank (>=2); address width AddrW = $clog2(BankSize).
- DataWidth, 32, payload bits per word.
- EncWidth, get_cw_width(DataWidth), encoded word width including the overall parity MSB. Derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- scrub_trigger_i  in  1  request one scrub step; sampled in IDLE only
- bit_corrected_o  out  1  one-cycle pulse when a correction write is granted
- uncorrectable_o  out  1  one-cycle pulse when a scrub read shows a double error
- number_of_corrections_o  out  32  saturating count of granted correction writes
- number_of_uncorrectable_o  out  32  saturating count of double errors
- scrub_busy_o  out  1  high in any state other than IDLE
- intc_req_i  in  1  core request
- intc_we_i  in  1  core write enable
- intc_add_i  in  AddrW  core address
- intc_wdata_i  in  EncWidth  core write data (already encoded)
- intc_rdata_o  out  EncWidth  core read data; equals bank_rdata_i
- bank_req_o  out  1  bank request
- bank_we_o  out  1  bank write enable
- bank_add_o  out  AddrW  bank address
- bank_wdata_o  out  EncWidth  bank write data
- bank_rdata_i  in  EncWidth  bank read data; valid the cycle after a granted read

Behaviour:
- Reset (async, rst_ni=0):
  - State goes to IDLE; scrub_addr=0; both counters 0; cancel flag 0.
  - All pulses are 0; scrub_busy_o=0.
  - Bank outputs pass through core inputs (combinational, so bank_req_o=intc_req_i).
- Arbitration, combinational:
  - If intc_req_i=1, bank_* = intc_* and the scrubber is stalled.
  - Otherwise bank_* = the scrubber's request, or bank_req_o=0 if it has none.
  - The core is never stalled. No grant signal is needed.
- States:
  - IDLE: if scrub_trigger_i=1, go to READ; otherwise stay.
  - READ: the scrubber requests a read of scrub_addr.
    - If intc_req_i=1, stay in READ (retry next cycle).
    - Otherwise go to WAIT.
  - WAIT: no scrubber request; bank_rdata_i is decoded combinationally by ecc_decode.
    - double_error: pulse uncorrectable_o, increment its counter, scrub_addr++, go to IDLE.
    - single_error or parity_error: go to CORRECT.
    - No error: scrub_addr++, go to IDLE.
    - Register the corrected payload for CORRECT.
  - CORRECT: the scrubber requests a write to scrub_addr with ecc_encode(corrected payload).
    - If intc_req_i=1, stay (retry).
    - If granted: pulse bit_corrected_o, increment its counter, scrub_addr++, go to IDLE.
- Cancel rule:
  - A core write (intc_req_i & intc_we_i) to scrub_addr in WAIT or CORRECT sets the cancel flag.
  - In WAIT with cancel set, or in CORRECT on the cycle cancel sets: drop the correction (no write, no pulse, no count), scrub_addr++, go to IDLE.
  - The cancel flag clears on entering IDLE.
  - A core read of scrub_addr does not cancel.
- Wrap: scrub_addr increments from BankSize-1 to 0.
- Counters saturate at 32'hFFFF_FFFF; a further event still pulses its output but does not change the count.
- A trigger in a non-IDLE state is dropped (no queuing).
- Latency with no contention:
  - Clean word: trigger → IDLE 3 cycles later.
  - Correctable word: trigger → IDLE 4 cycles later.
- Reset asserted mid-scrub: state is lost immediately; no partial write is issued after deassertion.

Decomposition:
- Reuse ecc_pkg for get_parity_width and get_cw_width.
- Add scrub_state_e {IDLE, READ, WAIT, CORRECT} to ecc_pkg.
- Instantiate existing ecc_decode (on bank_rdata_i) and ecc_encode (on the corrected payload).
- No new sub-module; the arbiter mux is inline.

Test Plan:
- Clean word at address 0, one trigger, no core traffic → one read at addr 0, no write, no pulses, scrub_addr=1, IDLE after 3 cycles.
- Word at address 5 with code_word bit 2 flipped, scrub reaches addr 5 → correction write of the correctly encoded payload, bit_corrected_o pulse, number_of_corrections_o=1.
- Two bits flipped at address 7 → no write, uncorrectable_o pulse, number_of_uncorrectable_o=1, scrub_addr=8.
- Single error at address 3, core writes addr 3 during WAIT → scrubber issues no write, no pulse, bank holds core data, scrub_addr=4.
- intc_req_i held high for 10 cycles during READ → scrubber stays in READ and the core sees every access unmodified; read issues the cycle after intc_req_i drops.
- BankSize=4, four triggers → scrub_addr returns to 0. With the counter preloaded to 32'hFFFF_FFFF, a correction still pulses bit_corrected_o and the count stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared SECDED helpers and scrub FSM state type.
//   get_parity_width(k) : Hamming check bits needed for k payload bits
//   get_cw_width(k)     : full code word width (payload + check bits + overall parity MSB)
//   scrub_state_e       : scrub engine states
package ecc_pkg;

   function automatic int unsigned get_parity_width(input int unsigned data_width);
      int unsigned p;
      p = 1;
      while ((32'd1 << p) < (data_width + p + 1)) p++;
      return p;
   endfunction

   function automatic int unsigned get_cw_width(input int unsigned data_width);
      return data_width + get_parity_width(data_width) + 1;
   endfunction

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WAIT,
      CORRECT
   } scrub_state_e;

endpackage

// File: rtl/ecc_decode.sv
// ecc_decode: SECDED decoder matching ecc_encode.
//   code_word_i    : received word
//   data_o         : payload with a single Hamming-position error repaired
//   single_error_o : one bit in positions 1..HamW was flipped (repaired)
//   double_error_o : uncorrectable (two errors, or an impossible syndrome)
//   parity_error_o : only the overall parity MSB is wrong (payload intact)
module ecc_decode import ecc_pkg::*; #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned EncWidth  = get_cw_width(DataWidth)
) (
   input  logic [EncWidth-1:0]  code_word_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 single_error_o,
   output logic                 double_error_o,
   output logic                 parity_error_o
);

   localparam int unsigned ParW   = get_parity_width(DataWidth);
   localparam int unsigned HamW   = DataWidth + ParW;
   localparam int unsigned CwIdxW = $clog2(EncWidth);
   localparam int unsigned DIdxW  = (DataWidth > 1) ? $clog2(DataWidth) : 1;

   always_comb begin
      logic [EncWidth-1:0] cw;
      logic                overall;
      int unsigned         syn;
      int unsigned         d;
      cw             = code_word_i;
      overall        = ^code_word_i;
      syn            = 0;
      d              = 0;
      data_o         = '0;
      single_error_o = 1'b0;
      double_error_o = 1'b0;
      parity_error_o = 1'b0;
      // syndrome = XOR of the positions of all set bits; names the flipped position
      for (int unsigned pos = 1; pos <= HamW; pos++) begin
         if (cw[CwIdxW'(pos - 1)]) syn ^= pos;
      end
      if (syn == 0) begin
         parity_error_o = overall;
      end else if (overall && (syn <= HamW)) begin
         single_error_o           = 1'b1;
         cw[CwIdxW'(syn - 1)]     = ~cw[CwIdxW'(syn - 1)];
      end else begin
         double_error_o = 1'b1;
      end
      for (int unsigned pos = 1; pos <= HamW; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            data_o[DIdxW'(d)] = cw[CwIdxW'(pos - 1)];
            d++;
         end
      end
   end

endmodule

// File: rtl/ecc_encode.sv
// ecc_encode: SECDED encoder (Hamming positions 1..HamW, overall parity in the MSB).
//   data_i      : payload
//   code_word_o : encoded word; bit (pos-1) holds Hamming position pos, check bits at powers of two
module ecc_encode import ecc_pkg::*; #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned EncWidth  = get_cw_width(DataWidth)
) (
   input  logic [DataWidth-1:0] data_i,
   output logic [EncWidth-1:0]  code_word_o
);

   localparam int unsigned ParW   = get_parity_width(DataWidth);
   localparam int unsigned HamW   = DataWidth + ParW;
   localparam int unsigned CwIdxW = $clog2(EncWidth);
   localparam int unsigned DIdxW  = (DataWidth > 1) ? $clog2(DataWidth) : 1;

   always_comb begin
      logic [EncWidth-1:0] cw;
      logic                par;
      int unsigned         d;
      cw  = '0;
      par = 1'b0;
      d   = 0;
      // scatter payload into the non-power-of-two positions
      for (int unsigned pos = 1; pos <= HamW; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            cw[CwIdxW'(pos - 1)] = data_i[DIdxW'(d)];
            d++;
         end
      end
      // check bit i covers every position with bit i set; its own slot is still 0 here
      for (int unsigned i = 0; i < ParW; i++) begin
         par = 1'b0;
         for (int unsigned pos = 1; pos <= HamW; pos++) begin
            if (((pos >> i) & 1) != 0) par ^= cw[CwIdxW'(pos - 1)];
         end
         cw[CwIdxW'((32'd1 << i) - 1)] = par;
      end
      cw[EncWidth-1] = ^cw[HamW-1:0];
      code_word_o    = cw;
   end

endmodule

// File: rtl/ecc_scrubber.sv
// ecc_scrubber: background scrub controller for one SECDED-protected single-port SRAM bank.
//   clk_i, rst_ni                  : clock, async active-low reset
//   scrub_trigger_i                : start one scrub step (honoured in IDLE only)
//   bit_corrected_o                : pulse when a correction write reaches the bank
//   uncorrectable_o                : pulse when a scrubbed word has a double error
//   number_of_corrections_o        : saturating count of correction writes
//   number_of_uncorrectable_o      : saturating count of double errors
//   scrub_busy_o                   : engine not in IDLE
//   intc_*                         : core port (always wins the bank)
//   bank_*                         : SRAM bank port; read data valid the cycle after a read
module ecc_scrubber import ecc_pkg::*; #(
   parameter int unsigned BankSize  = 256,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned EncWidth  = get_cw_width(DataWidth),
   parameter int unsigned AddrW     = $clog2(BankSize)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                scrub_trigger_i,
   output logic                bit_corrected_o,
   output logic                uncorrectable_o,
   output logic [31:0]         number_of_corrections_o,
   output logic [31:0]         number_of_uncorrectable_o,
   output logic                scrub_busy_o,
   input  logic                intc_req_i,
   input  logic                intc_we_i,
   input  logic [AddrW-1:0]    intc_add_i,
   input  logic [EncWidth-1:0] intc_wdata_i,
   output logic [EncWidth-1:0] intc_rdata_o,
   output logic                bank_req_o,
   output logic                bank_we_o,
   output logic [AddrW-1:0]    bank_add_o,
   output logic [EncWidth-1:0] bank_wdata_o,
   input  logic [EncWidth-1:0] bank_rdata_i
);

   scrub_state_e         state_q, state_d;
   logic [AddrW-1:0]     scrub_addr_q;
   logic                 cancel_q;
   logic [31:0]          corr_cnt_q, unc_cnt_q;
   logic [DataWidth-1:0] payload_q;

   logic                 scr_req, scr_we;
   logic                 addr_inc, payload_load, cancel_hit;
   logic [DataWidth-1:0] dec_data;
   logic                 dec_single, dec_double, dec_parity;
   logic [EncWidth-1:0]  enc_cw;

   ecc_decode #(.DataWidth(DataWidth), .EncWidth(EncWidth)) u_dec (
      .code_word_i    (bank_rdata_i),
      .data_o         (dec_data),
      .single_error_o (dec_single),
      .double_error_o (dec_double),
      .parity_error_o (dec_parity)
   );

   ecc_encode #(.DataWidth(DataWidth), .EncWidth(EncWidth)) u_enc (
      .data_i      (payload_q),
      .code_word_o (enc_cw)
   );

   // A core write landing on the word being scrubbed makes our repaired copy stale.
   assign cancel_hit = intc_req_i && intc_we_i && (intc_add_i == scrub_addr_q) &&
                       ((state_q == WAIT) || (state_q == CORRECT));

   always_comb begin
      state_d         = state_q;
      scr_req         = 1'b0;
      scr_we          = 1'b0;
      addr_inc        = 1'b0;
      payload_load    = 1'b0;
      bit_corrected_o = 1'b0;
      uncorrectable_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (scrub_trigger_i) state_d = READ;
         end
         READ: begin
            scr_req = 1'b1;
            if (!intc_req_i) state_d = WAIT;
         end
         WAIT: begin
            payload_load = 1'b1;
            if (dec_double) begin
               uncorrectable_o = 1'b1;
               addr_inc        = 1'b1;
               state_d         = IDLE;
            end else if ((dec_single || dec_parity) && !(cancel_q || cancel_hit)) begin
               state_d = CORRECT;
            end else begin
               addr_inc = 1'b1;
               state_d  = IDLE;
            end
         end
         CORRECT: begin
            if (cancel_q || cancel_hit) begin
               addr_inc = 1'b1;
               state_d  = IDLE;
            end else begin
               scr_req = 1'b1;
               scr_we  = 1'b1;
               if (!intc_req_i) begin
                  bit_corrected_o = 1'b1;
                  addr_inc        = 1'b1;
                  state_d         = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Core has absolute priority; the scrubber only sees the bank when the core is quiet.
   always_comb begin
      if (intc_req_i) begin
         bank_req_o   = 1'b1;
         bank_we_o    = intc_we_i;
         bank_add_o   = intc_add_i;
         bank_wdata_o = intc_wdata_i;
      end else begin
         bank_req_o   = scr_req;
         bank_we_o    = scr_we;
         bank_add_o   = scrub_addr_q;
         bank_wdata_o = enc_cw;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         scrub_addr_q <= '0;
         cancel_q     <= 1'b0;
         corr_cnt_q   <= '0;
         unc_cnt_q    <= '0;
         payload_q    <= '0;
      end else begin
         state_q  <= state_d;
         cancel_q <= (state_d == IDLE) ? 1'b0 : (cancel_q || cancel_hit);
         if (addr_inc) begin
            scrub_addr_q <= (scrub_addr_q == AddrW'(BankSize - 1)) ? '0 : scrub_addr_q + 1'b1;
         end
         if (payload_load) payload_q <= dec_data;
         if (bit_corrected_o && (corr_cnt_q != '1)) corr_cnt_q <= corr_cnt_q + 32'd1;
         if (uncorrectable_o && (unc_cnt_q != '1))  unc_cnt_q  <= unc_cnt_q + 32'd1;
      end
   end

   assign intc_rdata_o              = bank_rdata_i;
   assign scrub_busy_o              = (state_q != IDLE);
   assign number_of_corrections_o   = corr_cnt_q;
   assign number_of_uncorrectable_o = unc_cnt_q;

endmodule
